uart_link_scheduler: RTL and testbench

Shares one uart transceiver (run/din/dout/done/err interface) among N_REQ requesters. Arbitrates round-robin and sequences the uart through load (run=0) and transfer (run=1) phases. Retries on parity error and guards each transfer with a timeout. Returns the received byte and status to the granted requester. Sits between the client logic and the single uart instance.

---
 rtl/uart_link_scheduler.sv | 132 +++++++++++++
 tb/tb_uart_link_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_link_scheduler.sv
// uart_link_scheduler
//   Shares one uart transceiver among N_REQ requesters. Grants are issued
//   round-robin. Each accepted request is sequenced through a one-cycle load
//   phase (run=0) and a run phase (run=1). Parity errors are retried up to
//   MAX_RETRY times, and every run phase is bounded by TIMEOUT cycles. The
//   received byte and its status are returned to the granted requester.
//
// Ports
//   clk_in, rst_n       clock, async active-low reset
//   req / req_data      per-requester request and byte (slice i*DATA_W)
//   gnt                 one-hot grant pulse
//   busy                grant cycle through response cycle
//   rsp_*               result; rsp_valid pulses, the fields hold
//   uart_run/uart_din   control and data to the uart
//   uart_dout/done/err  results from the uart
module uart_link_scheduler #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 32,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [2:0]              rsp_retries,
  output logic                    uart_run,
  output logic [DATA_W-1:0]       uart_din,
  input  logic [DATA_W-1:0]       uart_dout,
  input  logic                    uart_done,
  input  logic                    uart_err
);

  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, id_q, pick;
  logic [DATA_W-1:0]   din_q;
  logic [2:0]          retry_q;
  logic [TMR_W-1:0]    tmr_q;
  logic                found, grant, tmo, retry_ok;
  int unsigned         idx_c;

  // First asserted request at or after rr_ptr, wrapping upward.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx_c = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_c = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && req[idx_c]) begin
        found = 1'b1;
        pick  = ID_W'(idx_c);
      end
    end
  end

  // The grant is combinational in IDLE; gating with rst_n keeps gnt low
  // while reset is held even if requests are already asserted.
  assign grant    = (state_q == IDLE) && found && rst_n;
  assign gnt      = grant ? (N_REQ'(1) << pick) : '0;
  assign busy     = (state_q != IDLE) || grant;
  assign uart_run = (state_q == RUN);
  assign rsp_valid = (state_q == RESP);
  assign uart_din = din_q;

  assign tmo      = (tmr_q == TMR_W'(TIMEOUT - 1));
  assign retry_ok = uart_err && (retry_q < 3'(MAX_RETRY));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN: begin
        // done wins over a timer expiring in the same cycle
        if (uart_done)  state_d = retry_ok ? LOAD : RESP;
        else if (tmo)   state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      din_q       <= '0;
      retry_q     <= '0;
      tmr_q       <= '0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_retries <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        id_q     <= pick;
        din_q    <= req_data[pick*DATA_W +: DATA_W];
        retry_q  <= '0;
        rr_ptr_q <= (pick == ID_W'(N_REQ - 1)) ? '0 : pick + ID_W'(1);
      end
      if (state_q == LOAD) tmr_q <= '0;
      if (state_q == RUN) begin
        tmr_q <= tmr_q + TMR_W'(1);
        if (uart_done && retry_ok) begin
          retry_q <= retry_q + 3'd1;
        end else if (uart_done || tmo) begin
          rsp_id      <= id_q;
          rsp_retries <= retry_q;
          rsp_data    <= uart_done ? uart_dout : '0;
          rsp_err     <= uart_done && uart_err;
          rsp_timeout <= !uart_done;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_link_scheduler.sv
module tb_uart_link_scheduler;
  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  gnt;
  logic        busy, rsp_valid, rsp_err, rsp_timeout;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic [2:0]  rsp_retries;
  logic        uart_run, uart_done, uart_err;
  logic [7:0]  uart_din, uart_dout;

  uart_link_scheduler #(.N_REQ(4), .DATA_W(8), .MAX_RETRY(2), .TIMEOUT(32)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .rsp_retries(rsp_retries), .uart_run(uart_run), .uart_din(uart_din),
    .uart_dout(uart_dout), .uart_done(uart_done), .uart_err(uart_err));

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_err = 0;
  int cyc = 0, gcyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // uart model: done on RUN cycle done_cyc (0 = never), parity error on the
  // first err_att attempts of a transaction, dout = din ^ dmask when done.
  int         done_cyc = 12, err_att = 0, rcnt = 0, att = 0;
  logic [7:0] dmask = '0;
  always @(posedge clk_in) if (!uart_run) rcnt <= 0; else rcnt <= rcnt + 1;
  always @(posedge clk_in) if (|gnt) att <= 0; else if (uart_run && uart_done) att <= att + 1;
  assign uart_done = uart_run && (done_cyc != 0) && (rcnt == done_cyc - 1);
  assign uart_err  = uart_done && (att < err_att);
  assign uart_dout = uart_done ? (uart_din ^ dmask) : (uart_run ? 8'hEE : 8'hzz);

  // length of the most recent run-high stretch
  int rl = 0, rl_last = 0;
  always @(negedge clk_in) begin
    if (uart_run) rl <= rl + 1;
    else begin
      if (rl != 0) rl_last <= rl;
      rl <= 0;
    end
  end

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       err;
    logic       to;
    logic [2:0] retries;
    int         lat;
  } rsp_t;
  rsp_t exp_q[$];

  task automatic expect_rsp(input int id, input logic [7:0] d, input logic e,
                            input logic to, input int r, input int lat);
    rsp_t x;
    x.id = 2'(id); x.data = d; x.err = e; x.to = to; x.retries = 3'(r); x.lat = lat;
    exp_q.push_back(x);
  endtask

  // response monitor / scoreboard
  always @(negedge clk_in) begin
    if (|gnt) gcyc = cyc;
    if (rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        rsp_t x;
        x = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(x.id));
        chk("rsp_data", 32'(rsp_data), 32'(x.data));
        chk("rsp_err", 32'(rsp_err), 32'(x.err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(x.to));
        chk("rsp_retries", 32'(rsp_retries), 32'(x.retries));
        chk("rsp_latency", 32'(cyc - gcyc), 32'(x.lat));
      end
    end
  end

  task automatic wait_gnt(input int id, output int gc);
    bit seen = 0;
    gc = 0;
    #1;
    for (int i = 0; i < 300; i++) begin
      if (gnt != 0) begin seen = 1; break; end
      @(negedge clk_in);
    end
    if (!seen) chk("gnt_wait_expired", 0, 1);
    else begin
      gc = cyc;
      chk("gnt_onehot", 32'(gnt), 32'(1) << id);
      chk("busy_at_gnt", 32'(busy), 1);
      @(negedge clk_in);
      chk("gnt_pulse", 32'(gnt), 0);
    end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk_in);
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) chk("done_wait_expired", 0, 1);
  endtask

  task automatic wait_rsp();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      if (rsp_valid) begin ok = 1; break; end
    end
    if (!ok) chk("rsp_wait_expired", 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_run"}, 32'(uart_run), 0);
    chk({tag, "_din"}, 32'(uart_din), 0);
    chk({tag, "_rsp"}, {16'(0), rsp_valid, rsp_id, rsp_data, rsp_err, rsp_timeout, rsp_retries}, 0);
  endtask

  int gc, prev;
  int rr_ids[6] = '{0, 1, 2, 3, 0, 3};

  initial begin
    // reset state
    repeat (3) @(negedge clk_in);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // single loopback transfer
    @(negedge clk_in);
    req_data[15:8] = 8'hA5;
    req = 4'b0010;
    expect_rsp(1, 8'hA5, 0, 0, 0, 14);
    wait_gnt(1, gc);
    chk("uart_din", 32'(uart_din), 32'hA5);
    req = '0;
    wait_done();

    // round robin with all requests held from reset
    rst_n = 1'b0;
    req_data = 32'h13121110;
    req = 4'b1111;
    @(negedge clk_in);
    rst_n = 1'b1;
    foreach (rr_ids[k]) expect_rsp(rr_ids[k], 8'h10 + 8'(rr_ids[k]), 0, 0, 0, 14);
    prev = 0;
    foreach (rr_ids[k]) begin
      wait_gnt(rr_ids[k], gc);
      if (k > 0) chk("rr_gap", 32'(gc - prev), 15);
      prev = gc;
      if (k == 3) req = 4'b1001;
      if (k == 5) req = '0;
    end
    wait_done();

    // parity errors on the first two attempts, then on every attempt
    req_data[7:0] = 8'h3C;
    err_att = 2;
    req = 4'b0001;
    expect_rsp(0, 8'h3C, 0, 0, 2, 40);
    wait_gnt(0, gc);
    req = '0;
    wait_done();
    err_att = 7;
    req = 4'b0001;
    expect_rsp(0, 8'h3C, 1, 0, 2, 40);
    wait_gnt(0, gc);
    req = '0;
    wait_done();
    err_att = 0;

    // timeout, with requester 2 pending behind it
    done_cyc = 0;
    req_data[15:8] = 8'h77;
    req_data[23:16] = 8'hC3;
    req = 4'b0010;
    expect_rsp(1, 8'h00, 0, 1, 0, 34);
    expect_rsp(2, 8'hC3, 0, 0, 0, 14);
    wait_gnt(1, gc);
    req = 4'b0100;
    wait_rsp();
    done_cyc = 12;
    @(negedge clk_in);
    chk("timeout_run_len", 32'(rl_last), 32);
    wait_gnt(2, gc);
    req = '0;
    wait_done();

    // reset during RUN loses the transfer; arbitration restarts at 0
    req_data[23:16] = 8'h99;
    req = 4'b0100;
    wait_gnt(2, gc);
    req = '0;
    repeat (4) @(negedge clk_in);
    chk("pre_reset_run", 32'(uart_run), 1);
    #2 rst_n = 1'b0;
    req = 4'b0101;
    req_data[7:0] = 8'h42;
    #1 chk_all_zero("midrst");
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    expect_rsp(0, 8'h42, 0, 0, 0, 14);
    expect_rsp(2, 8'h99, 0, 0, 0, 14);
    wait_gnt(0, gc);
    req = 4'b0100;
    wait_gnt(2, gc);
    req = '0;
    wait_done();

    // done on the same cycle the timer expires
    done_cyc = 32;
    dmask = 8'hFF;
    req_data[31:24] = 8'h5A;
    req = 4'b1000;
    expect_rsp(3, 8'hA5, 0, 0, 0, 34);
    wait_gnt(3, gc);
    req = '0;
    wait_done();
    done_cyc = 12;
    dmask = '0;

    repeat (3) @(negedge clk_in);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit got=1 exp=0");
    $fatal(1, "time limit");
  end
endmodule
